// File: rtl/fetch_seq.sv
// PC sequencer / fetch controller. Build option: BR_DELAY_SLOT_EN (MIPS delay slot).
// Latency: ack-to-slot 1 cycle, 1 instruction per 2 cycles.
// Backpressure: stall_i holds the slot. One extra response parks in a hold buffer, and fetching stops until the slot drains.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic        slot_vld_n;
    logic [31:0] slot_pc_n, slot_instr_n;
    logic        hold_vld, hold_vld_n;
    logic [31:0] hold_pc, hold_pc_n, hold_instr, hold_instr_n;
    logic        flush_n;
`ifdef BR_DELAY_SLOT_EN
    logic        pend_vld, pend_vld_n;
    logic [31:0] pend_pc, pend_pc_n;
`endif

    logic        consume;
    logic        ack;
    logic [31:0] tgt;

    assign consume = if_valid & ~stall_i;
    assign ack     = imem_req & imem_ack;
    assign tgt     = redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= 32'h0;
            if_valid   <= 1'b0;
            if_pc      <= 32'h0;
            if_instr   <= 32'h0;
            flush      <= 1'b0;
            hold_vld   <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
`ifdef BR_DELAY_SLOT_EN
            pend_vld   <= 1'b0;
            pend_pc    <= 32'h0;
`endif
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            imem_req   <= req_n;
            imem_addr  <= addr_n;
            if_valid   <= slot_vld_n;
            if_pc      <= slot_pc_n;
            if_instr   <= slot_instr_n;
            flush      <= flush_n;
            hold_vld   <= hold_vld_n;
            hold_pc    <= hold_pc_n;
            hold_instr <= hold_instr_n;
`ifdef BR_DELAY_SLOT_EN
            pend_vld   <= pend_vld_n;
            pend_pc    <= pend_pc_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_n        = imem_req;
        addr_n       = imem_addr;
        slot_vld_n   = if_valid & ~consume;
        slot_pc_n    = if_pc;
        slot_instr_n = if_instr;
        hold_vld_n   = hold_vld;
        hold_pc_n    = hold_pc;
        hold_instr_n = hold_instr;
        flush_n      = 1'b0;
`ifdef BR_DELAY_SLOT_EN
        pend_vld_n   = pend_vld;
        pend_pc_n    = pend_pc;
`endif

        case (state)
            IDLE: begin
                req_n   = 1'b1;
                addr_n  = pc;
                state_n = REQ;
            end
            REQ: begin
                if (ack) begin
                    req_n = 1'b0;
                    pc_n  = pc + 32'd4;
`ifdef BR_DELAY_SLOT_EN
                    // Delay-slot response just landed: continue at the branch target.
                    if (pend_vld) begin
                        pc_n       = pend_pc;
                        pend_vld_n = 1'b0;
                    end
`endif
                    if (!if_valid || consume) begin
                        slot_vld_n   = 1'b1;
                        slot_pc_n    = imem_addr;
                        slot_instr_n = imem_rdata;
                        state_n      = IDLE;
                    end else begin
                        hold_vld_n   = 1'b1;
                        hold_pc_n    = imem_addr;
                        hold_instr_n = imem_rdata;
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (consume) begin
                    slot_vld_n   = 1'b1;
                    slot_pc_n    = hold_pc;
                    slot_instr_n = hold_instr;
                    hold_vld_n   = 1'b0;
                    state_n      = IDLE;
                end
            end
            DROP: begin
                if (ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (redirect_valid) begin
`ifdef BR_DELAY_SLOT_EN
            // The oldest instruction left in the fetcher is the delay slot.
            case (state)
                IDLE: begin
                    if (if_valid && !consume) begin
                        pc_n   = tgt;
                        addr_n = tgt;
                    end else begin
                        pend_vld_n = 1'b1;
                        pend_pc_n  = tgt;
                    end
                end
                REQ: begin
                    if (ack) begin
                        pc_n = tgt;
                    end else begin
                        pend_vld_n = 1'b1;
                        pend_pc_n  = tgt;
                    end
                end
                HOLD: begin
                    pc_n = tgt;
                    if (!consume) begin
                        hold_vld_n = 1'b0;
                        flush_n    = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: pc_n = tgt;
            endcase
`else
            pc_n       = tgt;
            slot_vld_n = 1'b0;
            hold_vld_n = 1'b0;
            flush_n    = 1'b1;
            // An in-flight request must still be retired, so its response is eaten in DROP.
            if ((state == REQ || state == DROP) && !ack) begin
                state_n = DROP;
            end else begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq (default build): sequential fetch, stall/hold, redirects, PC wrap, reset.
module tb_fetch_seq;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_seq #(.RESET_PC(32'h00003000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .flush          (flush)
    );

    // Memory content is a fixed function of the address.
    assign imem_rdata = imem_addr ^ 32'hDEAD0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr,         32'h0);
        chk("rst_vld",   {31'b0, if_valid}, 32'h0);
        chk("rst_pc",    if_pc,             32'h0);
        chk("rst_instr", if_instr,          32'h0);
        chk("rst_flush", {31'b0, flush},    32'h0);
        tick(); tick();
        rst = 1'b0;

        // Sequential fetch, ack in the first REQ cycle
        tick();
        chk("seq0_req",  {31'b0, imem_req}, 32'h1);
        chk("seq0_addr", imem_addr,         32'h00003000);
        chk("seq0_vld",  {31'b0, if_valid}, 32'h0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("seq0_slot_vld", {31'b0, if_valid}, 32'h1);
        chk("seq0_slot_pc",  if_pc,             32'h00003000);
        chk("seq0_instr",    if_instr,          32'hDEAD3000);
        chk("seq0_req_drop", {31'b0, imem_req}, 32'h0);
        tick();
        chk("seq1_addr",     imem_addr,         32'h00003004);
        chk("seq1_consumed", {31'b0, if_valid}, 32'h0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("seq1_slot_pc", if_pc, 32'h00003004);
        chk("seq1_flush",   {31'b0, flush}, 32'h0);
        tick();
        chk("seq2_addr", imem_addr, 32'h00003008);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("seq2_slot_pc", if_pc,    32'h00003008);
        chk("seq2_instr",   if_instr, 32'hDEAD3008);

        // Stall: second response parks in the hold buffer
        stall_i = 1'b1;
        tick();
        chk("hold_req_addr", imem_addr, 32'h0000300C);
        chk("hold_slot_kept", if_pc,    32'h00003008);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("hold_req_drop", {31'b0, imem_req}, 32'h0);
        chk("hold_slot_vld", {31'b0, if_valid}, 32'h1);
        chk("hold_slot_pc",  if_pc,             32'h00003008);
        tick();
        chk("hold_noreq_a", {31'b0, imem_req}, 32'h0);
        tick();
        chk("hold_noreq_b", {31'b0, imem_req}, 32'h0);
        chk("hold_slot_pc_b", if_pc, 32'h00003008);
        stall_i = 1'b0;
        tick();
        chk("hold_move_vld",   {31'b0, if_valid}, 32'h1);
        chk("hold_move_pc",    if_pc,             32'h0000300C);
        chk("hold_move_instr", if_instr,          32'hDEAD300C);
        chk("hold_move_noreq", {31'b0, imem_req}, 32'h0);
        tick();
        chk("post_hold_req",  {31'b0, imem_req}, 32'h1);
        chk("post_hold_addr", imem_addr,         32'h00003010);
        chk("post_hold_vld",  {31'b0, if_valid}, 32'h0);

        // Redirect while a request is outstanding, ack arrives later
        redirect_valid = 1'b1; redirect_pc = 32'h00003101;
        tick(); redirect_valid = 1'b0;
        chk("drop_flush",    {31'b0, flush},    32'h1);
        chk("drop_req_held", {31'b0, imem_req}, 32'h1);
        chk("drop_addr",     imem_addr,         32'h00003010);
        chk("drop_vld",      {31'b0, if_valid}, 32'h0);
        tick();
        chk("drop_flush_once", {31'b0, flush},    32'h0);
        chk("drop_req_wait",   {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("drop_discard_vld", {31'b0, if_valid}, 32'h0);
        chk("drop_req_fall",    {31'b0, imem_req}, 32'h0);
        tick();
        chk("redir_tgt_addr", imem_addr,         32'h00003100);
        chk("redir_tgt_vld",  {31'b0, if_valid}, 32'h0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("redir_tgt_pc",    if_pc,    32'h00003100);
        chk("redir_tgt_instr", if_instr, 32'hDEAD3100);

        // Redirect coinciding with ack
        tick();
        chk("same_req_addr", imem_addr, 32'h00003104);
        imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h00004000;
        tick(); imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("same_vld",   {31'b0, if_valid}, 32'h0);
        chk("same_flush", {31'b0, flush},    32'h1);
        chk("same_req",   {31'b0, imem_req}, 32'h0);
        tick();
        chk("same_tgt_addr", imem_addr,         32'h00004000);
        chk("same_tgt_req",  {31'b0, imem_req}, 32'h1);
        chk("same_vld_b",    {31'b0, if_valid}, 32'h0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("same_tgt_pc", if_pc, 32'h00004000);

        // Redirect beats stall; low bits ignored; PC wraps to zero
        stall_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        tick(); stall_i = 1'b0; redirect_valid = 1'b0;
        chk("stall_redir_vld",   {31'b0, if_valid}, 32'h0);
        chk("stall_redir_flush", {31'b0, flush},    32'h1);
        tick();
        chk("wrap_top_addr", imem_addr, 32'hFFFFFFFC);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("wrap_top_pc",    if_pc,    32'hFFFFFFFC);
        chk("wrap_top_instr", if_instr, 32'h2152FFFC);
        tick();
        chk("wrap_zero_addr", imem_addr, 32'h00000000);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        chk("wrap_zero_pc",    if_pc,    32'h00000000);
        chk("wrap_zero_instr", if_instr, 32'hDEAD0000);

        // Asynchronous reset in the middle of a request
        tick();
        chk("mid_req",      {31'b0, imem_req}, 32'h1);
        chk("mid_req_addr", imem_addr,         32'h00000004);
        #2 rst = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_req}, 32'h0);
        chk("arst_addr",  imem_addr,         32'h0);
        chk("arst_vld",   {31'b0, if_valid}, 32'h0);
        chk("arst_pc",    if_pc,             32'h0);
        chk("arst_instr", if_instr,          32'h0);
        chk("arst_flush", {31'b0, flush},    32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("restart_req",  {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr,         32'h00003000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
